// File: rtl/reg_axi_slv_pkg.sv
// ============================================================================
// Module   : reg_axi_slv_pkg
// Brief    : Shared register-bus types, widths, response codes and FSM states.
// Revision : 1.0
// ============================================================================
`default_nettype none

package reg_axi_slv_pkg;

    localparam int R_AWID  = 32;
    localparam int R_DWID  = 32;
    localparam int R_IDWID = 4;

    localparam logic [R_DWID-1:0] REG_BAD_DATA = 32'hDEAD_ADDE;

    typedef enum logic [1:0] {
        AXI_OKAY_RESP   = 2'b00,
        AXI_EXOKAY_RESP = 2'b01,
        AXI_SLVERR_RESP = 2'b10,
        AXI_DECERR_RESP = 2'b11
    } t_AXI_RESP_e;

    typedef enum logic [2:0] {
        W_IDLE   = 3'd0,
        W_HAVE_A = 3'd1,
        W_HAVE_D = 3'd2,
        W_EXEC   = 3'd3,
        W_RESP   = 3'd4
    } t_REGSLV_WR_ST_e;

    typedef enum logic [1:0] {
        R_IDLE = 2'd0,
        R_EXEC = 2'd1,
        R_DATA = 2'd2,
        R_RESP = 2'd3
    } t_REGSLV_RD_ST_e;

    typedef struct packed {
        logic                  awvalid;
        logic [R_AWID-1:0]     awaddr;
        logic [R_IDWID-1:0]    awid;
        logic                  wvalid;
        logic [R_DWID-1:0]     wdata;
        logic [R_DWID/8-1:0]   wstrb;
        logic                  arvalid;
        logic [R_AWID-1:0]     araddr;
        logic [R_IDWID-1:0]    arid;
        logic                  bready;
        logic                  rready;
        logic                  clk_en;
    } t_reg_req_s;

    typedef struct packed {
        logic                  awready;
        logic                  wready;
        logic                  bvalid;
        logic [R_IDWID-1:0]    bid;
        t_AXI_RESP_e           bresp;
        logic                  arready;
        logic                  rvalid;
        logic [R_IDWID-1:0]    rid;
        logic [R_DWID-1:0]     rdata;
        t_AXI_RESP_e           rresp;
    } t_reg_resp_s;

endpackage

`default_nettype wire

// File: rtl/reg_axi_slv_if.sv
// ============================================================================
// Module   : reg_axi_slv_if
// Brief    : Register channel bundle: request from master, response from slave.
// Revision : 1.0
// ============================================================================
`default_nettype none

interface reg_axi_slv_if;
    import reg_axi_slv_pkg::*;

    t_reg_req_s  reg_req;
    t_reg_resp_s reg_resp;

    modport master (output reg_req, input  reg_resp);
    modport slave  (input  reg_req, output reg_resp);
endinterface

`default_nettype wire

// File: rtl/reg_axi_addr_dec.sv
// ============================================================================
// Module   : reg_axi_addr_dec
// Brief    : Range/alignment decode to an AXI response; the partial-strobe
//            check is compiled in with REG_AXI_SLV_STRB_CHK_EN.
// Revision : 1.0
// ============================================================================
`default_nettype none

module reg_axi_addr_dec
    import reg_axi_slv_pkg::*;
#(
    parameter logic [R_AWID-1:0] BASE_ADDR = 32'h0000_0000,
    parameter logic [R_AWID-1:0] ADDR_SPAN = 32'h0000_1000
) (
    input  wire [R_AWID-1:0]   addr,
    input  wire [R_DWID/8-1:0] strb,
    input  wire                is_wr,
    output t_AXI_RESP_e        resp
);

    logic [R_AWID-1:0] w_off;
    logic              w_strb_bad;

    // Below-base addresses wrap to a huge offset and fail the range test.
    assign w_off = addr - BASE_ADDR;

`ifdef REG_AXI_SLV_STRB_CHK_EN
    assign w_strb_bad = is_wr && (strb != '1);
`else
    logic w_unused_strb;
    assign w_unused_strb = ^{is_wr, strb};
    assign w_strb_bad    = 1'b0;
`endif

    always_comb begin
        resp = AXI_OKAY_RESP;
        if (!(w_off < ADDR_SPAN))
            resp = AXI_DECERR_RESP;
        else if (addr[1:0] != 2'b00)
            resp = AXI_SLVERR_RESP;
        else if (w_strb_bad)
            resp = AXI_SLVERR_RESP;
    end

endmodule

`default_nettype wire

// File: rtl/reg_axi_slv.sv
// ============================================================================
// Module   : reg_axi_slv
// Brief    : Register-bus responder driving a flat register-bank backend.
//            Optional WSTRB check: REG_AXI_SLV_STRB_CHK_EN.
// Revision : 1.0
// ============================================================================
`default_nettype none

module reg_axi_slv
    import reg_axi_slv_pkg::*;
#(
    parameter logic [R_AWID-1:0] BASE_ADDR = 32'h0000_0000,
    parameter logic [R_AWID-1:0] ADDR_SPAN = 32'h0000_1000
) (
    input  wire                  clk,
    input  wire                  rst_n,
    reg_axi_slv_if.slave         bus,
    output logic                 bk_wr_en,
    output logic [R_AWID-1:0]    bk_wr_addr,
    output logic [R_DWID-1:0]    bk_wr_data,
    output logic [R_DWID/8-1:0]  bk_wr_strb,
    output logic                 bk_rd_en,
    output logic [R_AWID-1:0]    bk_rd_addr,
    input  wire  [R_DWID-1:0]    bk_rd_data
);

    t_REGSLV_WR_ST_e     r_wr_st, w_wr_st_nxt;
    t_REGSLV_RD_ST_e     r_rd_st, w_rd_st_nxt;
    logic [R_AWID-1:0]   r_awaddr, r_araddr;
    logic [R_IDWID-1:0]  r_awid, r_arid, r_bid, r_rid;
    logic [R_DWID-1:0]   r_wdata, r_rdata;
    logic [R_DWID/8-1:0] r_wstrb;
    logic                r_bvalid, r_rvalid;
    t_AXI_RESP_e         r_bresp, r_rresp, w_wr_dec, w_rd_dec;
    logic                w_act, w_awready, w_wready, w_arready;
    logic                w_aw_hs, w_w_hs, w_ar_hs;
    t_reg_resp_s         w_resp;

    // Readies are also held low while reset is asserted.
    assign w_act = bus.reg_req.clk_en & rst_n;

    reg_axi_addr_dec #(.BASE_ADDR(BASE_ADDR), .ADDR_SPAN(ADDR_SPAN)) u_wr_dec (
        .addr(r_awaddr), .strb(r_wstrb), .is_wr(1'b1), .resp(w_wr_dec)
    );
    reg_axi_addr_dec #(.BASE_ADDR(BASE_ADDR), .ADDR_SPAN(ADDR_SPAN)) u_rd_dec (
        .addr(r_araddr), .strb('1), .is_wr(1'b0), .resp(w_rd_dec)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_wr_st <= W_IDLE;
            r_rd_st <= R_IDLE;
        end else begin
            r_wr_st <= w_wr_st_nxt;
            r_rd_st <= w_rd_st_nxt;
        end
    end

    always_comb begin
        w_wr_st_nxt = r_wr_st;
        w_awready   = 1'b0;
        w_wready    = 1'b0;
        bk_wr_en    = 1'b0;
        case (r_wr_st)
            W_IDLE: begin
                w_awready = w_act;
                w_wready  = w_act;
                if (w_aw_hs && w_w_hs) w_wr_st_nxt = W_EXEC;
                else if (w_aw_hs)      w_wr_st_nxt = W_HAVE_A;
                else if (w_w_hs)       w_wr_st_nxt = W_HAVE_D;
            end
            W_HAVE_A: begin
                w_wready = w_act;
                if (w_w_hs) w_wr_st_nxt = W_EXEC;
            end
            W_HAVE_D: begin
                w_awready = w_act;
                if (w_aw_hs) w_wr_st_nxt = W_EXEC;
            end
            W_EXEC: begin
                bk_wr_en = w_act && (w_wr_dec == AXI_OKAY_RESP);
                if (w_act) w_wr_st_nxt = W_RESP;
            end
            W_RESP: begin
                if (w_act && bus.reg_req.bready) w_wr_st_nxt = W_IDLE;
            end
            default: w_wr_st_nxt = W_IDLE;
        endcase
    end

    always_comb begin
        w_rd_st_nxt = r_rd_st;
        w_arready   = 1'b0;
        bk_rd_en    = 1'b0;
        case (r_rd_st)
            R_IDLE: begin
                w_arready = w_act;
                if (w_ar_hs) w_rd_st_nxt = R_EXEC;
            end
            R_EXEC: begin
                bk_rd_en = w_act && (w_rd_dec == AXI_OKAY_RESP);
                if (w_act) w_rd_st_nxt = R_DATA;
            end
            R_DATA: begin
                if (w_act) w_rd_st_nxt = R_RESP;
            end
            R_RESP: begin
                if (w_act && bus.reg_req.rready) w_rd_st_nxt = R_IDLE;
            end
            default: w_rd_st_nxt = R_IDLE;
        endcase
    end

    assign w_aw_hs = w_awready & bus.reg_req.awvalid;
    assign w_w_hs  = w_wready  & bus.reg_req.wvalid;
    assign w_ar_hs = w_arready & bus.reg_req.arvalid;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_awaddr <= '0;
            r_awid   <= '0;
            r_wdata  <= '0;
            r_wstrb  <= '0;
            r_bvalid <= 1'b0;
            r_bid    <= '0;
            r_bresp  <= AXI_OKAY_RESP;
        end else begin
            if (w_aw_hs) begin
                r_awaddr <= bus.reg_req.awaddr;
                r_awid   <= bus.reg_req.awid;
            end
            if (w_w_hs) begin
                r_wdata <= bus.reg_req.wdata;
                r_wstrb <= bus.reg_req.wstrb;
            end
            if (w_act && r_wr_st == W_EXEC) begin
                r_bvalid <= 1'b1;
                r_bid    <= r_awid;
                r_bresp  <= w_wr_dec;
            end else if (w_act && r_wr_st == W_RESP && bus.reg_req.bready) begin
                r_bvalid <= 1'b0;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_araddr <= '0;
            r_arid   <= '0;
            r_rvalid <= 1'b0;
            r_rid    <= '0;
            r_rdata  <= '0;
            r_rresp  <= AXI_OKAY_RESP;
        end else begin
            if (w_ar_hs) begin
                r_araddr <= bus.reg_req.araddr;
                r_arid   <= bus.reg_req.arid;
            end
            if (w_act && r_rd_st == R_DATA) begin
                r_rvalid <= 1'b1;
                r_rid    <= r_arid;
                r_rresp  <= w_rd_dec;
                r_rdata  <= (w_rd_dec == AXI_OKAY_RESP) ? bk_rd_data : REG_BAD_DATA;
            end else if (w_act && r_rd_st == R_RESP && bus.reg_req.rready) begin
                r_rvalid <= 1'b0;
            end
        end
    end

    // Backend payloads are only meaningful alongside their strobe; zero otherwise.
    assign bk_wr_addr = bk_wr_en ? ((r_awaddr - BASE_ADDR) >> 2) : '0;
    assign bk_wr_data = bk_wr_en ? r_wdata : '0;
    assign bk_wr_strb = bk_wr_en ? r_wstrb : '0;
    assign bk_rd_addr = bk_rd_en ? ((r_araddr - BASE_ADDR) >> 2) : '0;

    always_comb begin
        w_resp         = '0;
        w_resp.awready = w_awready;
        w_resp.wready  = w_wready;
        w_resp.bvalid  = r_bvalid;
        w_resp.bid     = r_bid;
        w_resp.bresp   = r_bresp;
        w_resp.arready = w_arready;
        w_resp.rvalid  = r_rvalid;
        w_resp.rid     = r_rid;
        w_resp.rdata   = r_rdata;
        w_resp.rresp   = r_rresp;
    end

    assign bus.reg_resp = w_resp;

endmodule

`default_nettype wire
